nibble_serial_add_ctrl: RTL and testbench
=========================================

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: operand width is W = 4*NIBBLES bits; legal range is 2..8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0  input  1  requester 0 add request; held high until ack0.
REQ-005 a0, b0  input  W  requester 0 operands; stable while req0 is high.
REQ-006 cin0  input  1  requester 0 carry-in.
REQ-007 req1, a1, b1, cin1  input  1/W/W/1  requester 1 equivalents.
REQ-008 ack0, ack1  output  1  one-cycle pulse when that requester's operands are captured.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 done  output  1  one-cycle pulse marking a valid result.
REQ-011 done_id  output  1  requester served by the current or last result.
REQ-012 sum  output  W  result; held until the next done.
REQ-013 cout  output  1  carry-out of the full W-bit add; held with sum.

Function
REQ-014 The block SHALL perform all arithmetic through a single instance of the existing 4-bit ripple_carry_adder (ports a, b, cin, sum, cout), one nibble per cycle, LSB nibble first.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 IDLE with no request: stay in IDLE.
REQ-017 IDLE with any request sampled at an edge: capture the granted operands and cin into internal registers, set nibble index = 0, carry register = the granted cin, and go to RUN.
REQ-018 The corresponding ack pulse SHALL be high for exactly the first RUN cycle.
REQ-019 Arbitration is round-robin on a last_served pointer: with a single request, that request wins; with both requests, the requester other than last_served wins.
REQ-020 last_served SHALL update at each capture.
REQ-021 RUN SHALL last exactly NIBBLES cycles, with one nibble per edge: adder inputs are operand nibble[idx] and the carry register; the adder sum goes to result nibble[idx]; the adder cout goes to the carry register; idx increments.
REQ-022 At the edge that processes nibble NIBBLES-1, the FSM SHALL move to DONE and update sum, cout and done_id together.
REQ-023 DONE SHALL last one cycle (done=1) and then return to IDLE.
REQ-024 Latency: with the capture at edge E0, done is high in the cycle following edge E0+NIBBLES.
REQ-025 Throughput: the earliest next capture is edge E0+NIBBLES+2.
REQ-026 Requests SHALL be ignored outside IDLE; a request deasserted before its ack is dropped without side effects.
REQ-027 Carry SHALL propagate across nibble boundaries with no loss; cout equals bit W of a+b+cin.
REQ-028 sum, cout and done_id SHALL change only at the edge that enters DONE.

Reset
REQ-029 When rst is high at an edge, the block SHALL set: state=IDLE; ack0=ack1=busy=done=0; sum=0; cout=0; done_id=0; last_served=1 (requester 0 wins the first tie); idx=0; carry register=0.
REQ-030 rst SHALL take priority over all other inputs.
REQ-031 rst during RUN or DONE SHALL abort the operation: no done pulse, partial result discarded, and the block accepts requests from the first non-reset edge.

Verification
REQ-032 Simple add: req0, a0=0x1234, b0=0x4321, cin0=0 -> ack0 one cycle; done 5 cycles after capture; sum=0x5555, cout=0, done_id=0.
REQ-033 Full carry chain: req1, a1=0xFFFF, b1=0x0001, cin1=0 -> sum=0x0000, cout=1, done_id=1.
REQ-034 Carry-in propagation: a0=0xAAAA, b0=0x5555, cin0=1 -> sum=0x0000, cout=1; a0=b0=0xFFFF, cin0=1 -> sum=0xFFFF, cout=1.
REQ-035 Tie after reset: req0 and req1 held continuously -> grant order 0,1,0,1; each ack is one cycle; captures 6 cycles apart; no request starves.
REQ-036 Mid-run reset: rst pulsed in the 2nd RUN cycle -> busy=0, no done, sum=0 on the next cycle; a request reissued after reset completes correctly.
REQ-037 Request withdrawn during busy: a req1 pulse that falls before the FSM returns to IDLE -> no ack1, no operation.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder shared by two requesters. One 4-bit ripple adder is reused
// across NIBBLES cycles, and the carry is kept in a register between cycles.

module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic c1, c2, c3;

  assign sum[0] = a[0] ^ b[0] ^ cin;
  assign c1     = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
  assign sum[1] = a[1] ^ b[1] ^ c1;
  assign c2     = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
  assign sum[2] = a[2] ^ b[2] ^ c2;
  assign c3     = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
  assign sum[3] = a[3] ^ b[3] ^ c3;
  assign cout   = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));
endmodule

// state | meaning
// IDLE  | waiting for req0/req1; operands are captured on grant
// RUN   | one nibble per cycle, LSB first, NIBBLES cycles
// DONE  | result valid for one cycle (done=1)
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         cin0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         cin1,
  output logic         ack0,
  output logic         ack1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  op_a, op_b, res;
  logic          cur_id, last_served;
  logic          grant1;
  logic [3:0]    nib_sum;
  logic          nib_cout;

  // On a tie the requester that was not served last wins.
  assign grant1 = req1 & (~req0 | ~last_served);

  ripple_carry_adder u_rca (
    .a    (op_a[3:0]),
    .b    (op_b[3:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req0 | req1) state_nxt = RUN;
      RUN:     if (idx == IDX_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands shift right so the adder always sees the current nibble in [3:0];
  // finished nibbles shift into res from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      carry       <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      res         <= '0;
      cur_id      <= 1'b0;
      last_served <= 1'b1;
      sum         <= '0;
      cout        <= 1'b0;
      done_id     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            op_a        <= grant1 ? a1 : a0;
            op_b        <= grant1 ? b1 : b0;
            carry       <= grant1 ? cin1 : cin0;
            idx         <= '0;
            cur_id      <= grant1;
            last_served <= grant1;
          end
        end
        RUN: begin
          op_a  <= op_a >> 4;
          op_b  <= op_b >> 4;
          res   <= {nib_sum, res[W-1:4]};
          carry <= nib_cout;
          idx   <= idx + IW'(1);
          if (idx == IDX_LAST) begin
            sum     <= {nib_sum, res[W-1:4]};
            cout    <= nib_cout;
            done_id <= cur_id;
          end
        end
        default: ;
      endcase
    end
  end

  assign ack0 = (state == RUN) && (idx == '0) && !cur_id;
  assign ack1 = (state == RUN) && (idx == '0) && cur_id;
  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl: a timing/arithmetic model predicts
// grants and results at capture, and a monitor compares every cycle.

module tb_nibble_serial_add_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0, rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, cin0 = 1'b0, cin1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         ack0, ack1, busy, done, done_id, cout;
  logic [W-1:0] sum;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
    .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
    .ack0(ack0), .ack1(ack1), .busy(busy), .done(done),
    .done_id(done_id), .sum(sum), .cout(cout)
  );

  typedef struct {logic id; logic [W-1:0] s; logic c;} res_t;
  res_t sbq[$];

  int checks = 0, errors = 0;
  int cyc = 0, free_at = 0, ack_edge = -1, busy_lo = -1, busy_hi = -1, done_edge = -1, rst_edge = -1;
  logic ack_id = 1'b0, last = 1'b1, win;
  logic [W:0] tot;

  // Reference model: the block is free again N+2 edges after a capture;
  // results are plain (W+1)-bit sums.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      rst_edge  = cyc;
      free_at   = cyc + 1;
      ack_edge  = -1;
      busy_hi   = -1;
      done_edge = -1;
      last      = 1'b1;
    end else if (cyc >= free_at && (req0 || req1)) begin
      win = (req0 && req1) ? ~last : req1;
      if (win) tot = {1'b0, a1} + {1'b0, b1} + {{W{1'b0}}, cin1};
      else     tot = {1'b0, a0} + {1'b0, b0} + {{W{1'b0}}, cin0};
      sbq.push_back('{win, tot[W-1:0], tot[W]});
      last      = win;
      ack_id    = win;
      ack_edge  = cyc;
      busy_lo   = cyc;
      busy_hi   = cyc + N;
      done_edge = cyc + N;
      free_at   = cyc + N + 2;
    end
  end

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  logic [W-1:0] held_s = '0;
  logic         held_c = 1'b0, held_id = 1'b0;
  res_t         item;

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (cyc == rst_edge) begin
        sbq.delete();
        held_s  = '0;
        held_c  = 1'b0;
        held_id = 1'b0;
      end
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected cyc=%0d actual=1 required=0", cyc);
        end else begin
          item    = sbq.pop_front();
          held_s  = item.s;
          held_c  = item.c;
          held_id = item.id;
        end
      end
      chk("ack0", ack0, (cyc == ack_edge) && !ack_id);
      chk("ack1", ack1, (cyc == ack_edge) && ack_id);
      chk("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
      chk("done", done, cyc == done_edge);
      chk("sum", sum, held_s);
      chk("cout", cout, held_c);
      chk("done_id", done_id, held_id);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic got = 1'b0;
    if (id == 0) begin a0 = a; b0 = b; cin0 = c; req0 = 1'b1; end
    else         begin a1 = a; b1 = b; cin1 = c; req1 = 1'b1; end
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      got = (id == 0) ? ack0 : ack1;
    end
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout requester=%0d actual=0 required=1", id);
    end
  endtask

  task automatic wait_idle();
    logic idle = 1'b0;
    for (int k = 0; k < 60 && !idle; k++) begin
      tick();
      idle = !busy;
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  int   g_id[4];
  int   g_cyc[4];
  int   ng;
  logic ack1_seen;

  initial begin
    repeat (3) tick();
    rst = 1'b0;

    issue(0, 16'h1234, 16'h4321, 1'b0); wait_idle();
    issue(1, 16'hFFFF, 16'h0001, 1'b0); wait_idle();
    issue(0, 16'hAAAA, 16'h5555, 1'b1); wait_idle();
    issue(0, 16'hFFFF, 16'hFFFF, 1'b1); wait_idle();

    // both requesters held after a reset: grants must alternate 0,1,0,1
    rst = 1'b1; tick(); rst = 1'b0;
    a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'b1;
    a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    ng = 0;
    for (int k = 0; k < 200 && ng < 4; k++) begin
      tick();
      if (ack0 || ack1) begin
        g_id[ng]  = ack1 ? 1 : 0;
        g_cyc[ng] = cyc;
        ng++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("tie_grants", W'(ng), W'(4));
    for (int i = 0; i < ng; i++) chk("tie_order", W'(g_id[i]), W'(i % 2));
    for (int i = 1; i < ng; i++) chk("tie_spacing", W'(g_cyc[i] - g_cyc[i-1]), W'(N + 2));
    wait_idle();

    // reset in the second RUN cycle, then a fresh request
    issue(0, W'($urandom), W'($urandom), 1'b1);
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    issue(0, 16'h0F0F, 16'h00F1, 1'b0); wait_idle();

    // req1 pulse that falls while busy must be dropped
    issue(0, W'($urandom), W'($urandom), 1'b0);
    ack1_seen = 1'b0;
    tick(); req1 = 1'b1; a1 = W'($urandom); b1 = W'($urandom);
    tick(); ack1_seen |= ack1;
    tick(); ack1_seen |= ack1; req1 = 1'b0;
    wait_idle();
    chk("withdrawn_ack1", W'(ack1_seen), W'(0));

    for (int t = 0; t < 800; t++) begin
      tick();
      if (req0 && ack0) req0 = 1'b0;
      else if (req0 && $urandom_range(15) == 0) req0 = 1'b0;
      else if (!req0 && $urandom_range(3) == 0) begin
        a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom_range(1)); req0 = 1'b1;
      end
      if (req1 && ack1) req1 = 1'b0;
      else if (req1 && $urandom_range(15) == 0) req1 = 1'b0;
      else if (!req1 && $urandom_range(3) == 0) begin
        a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom_range(1)); req1 = 1'b1;
      end
      rst = ($urandom_range(199) == 0);
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    wait_idle();
    tick();
    chk("scoreboard_empty", W'(sbq.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
